// File: rtl/lzw_code_packer_if.sv
// lzw_code_packer_if: code input, flush/done and byte output bundle
// master = datapath/sink side, slave = packer side
interface lzw_code_packer_if #(
  parameter int CODE_WIDTH = 12
);
  logic [CODE_WIDTH-1:0] CodeIn;
  logic                  CodeValid;
  logic                  CodeReady;
  logic                  Flush;
  logic [7:0]            ByteOut;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  Done;
  logic [15:0]           ByteCount;

  modport master (
    output CodeIn, CodeValid, Flush,
    output ByteReady,
    input  CodeReady, ByteOut,
    input  ByteValid, Done, ByteCount
  );

  modport slave (
    input  CodeIn, CodeValid, Flush,
    input  ByteReady,
    output CodeReady, ByteOut,
    output ByteValid, Done, ByteCount
  );
endinterface

// File: rtl/lzw_code_packer.sv
// lzw_code_packer: packs 12-bit LZW codes MSB-first into bytes
// flush pads the last partial byte with zeros, then pulses Done
module lzw_code_packer (
  input  logic               Clock,
  input  logic               Reset,
  lzw_code_packer_if.slave   bus
);
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] CW = 5'd12;

  state_t      state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;

  logic code_ready;
  logic accept;
  logic hs;
  logic can_load;
  logic load_full;
  logic load_part;

  assign code_ready = (state_q == RUN)
                    && (bit_cnt_q < 5'd8)
                    && !Reset;
  assign accept    = bus.CodeValid && code_ready;
  assign hs        = byte_valid_q && bus.ByteReady;
  assign can_load  = !byte_valid_q || bus.ByteReady;
  assign load_full = can_load && (bit_cnt_q >= 5'd8);
  // Residual bits are already zero below the valid field.
  assign load_part = can_load
                   && (state_q == FLUSH)
                   && (bit_cnt_q != 5'd0)
                   && (bit_cnt_q < 5'd8);

  always_comb begin
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_cnt_d   = byte_cnt_q;
    state_d      = state_q;

    if (hs) begin
      byte_valid_d = 1'b0;
      byte_cnt_d   = byte_cnt_q + 16'd1;
    end

    unique case (1'b1)
      accept: begin
        acc_d = acc_q
              | (24'(bus.CodeIn)
                 << (CW - bit_cnt_q));
        bit_cnt_d = bit_cnt_q + CW;
      end
      load_full: begin
        byte_out_d   = acc_q[23:16];
        acc_d        = acc_q << 8;
        bit_cnt_d    = bit_cnt_q - 5'd8;
        byte_valid_d = 1'b1;
      end
      load_part: begin
        byte_out_d   = acc_q[23:16];
        acc_d        = '0;
        bit_cnt_d    = '0;
        byte_valid_d = 1'b1;
      end
      default: ;
    endcase

    unique case (state_q)
      RUN: begin
        if (bus.Flush) state_d = FLUSH;
      end
      FLUSH: begin
        if ((bit_cnt_q == 5'd0) && can_load)
          state_d = DONE;
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= RUN;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign bus.CodeReady = code_ready;
  assign bus.ByteOut   = byte_out_q;
  assign bus.ByteValid = byte_valid_q;
  assign bus.Done      = (state_q == DONE);
  assign bus.ByteCount = byte_cnt_q;
endmodule
